gray_checker: RTL and testbench
===============================

// Module: gray_checker
// PURPOSE
//   Monitor stage that sits downstream of the 5-bit Gray counter. It samples the
//   counter's Gray output, converts it to binary, and checks every clock that the
//   value either held (enable low) or advanced exactly one step (enable high).
//   It reports lock status, single-cycle error and wrap pulses, and a saturating
//   error count for bench and debug use.
// PARAMETERS
//   WIDTH       5  Gray/binary word width; must match the counter width.
//   ERR_CNT_W   8  Width of error_count; the count saturates at 2^ERR_CNT_W-1.
//   LOCK_COUNT  2  Consecutive good checks needed to enter LOCKED (range 1..15).
// PORTS
//   clk          in   1          Single clock; every register is on the rising edge.
//   reset_L      in   1          Asynchronous, active-low reset.
//   enable       in   1          Same enable net that drives the Gray counter.
//   gray_in      in   WIDTH      Gray output of the counter.
//   bin_out      out  WIDTH      Registered binary equivalent of gray_in.
//   bin_valid    out  1          High when bin_out holds a converted sample.
//   locked       out  1          High while state == LOCKED.
//   error        out  1          One-cycle pulse on a failed check in LOCKED.
//   error_count  out  ERR_CNT_W  Saturating count of error pulses.
//   wrap         out  1          One-cycle pulse on a good 2^WIDTH-1 -> 0 step.
// BEHAVIOUR
//   - Reset (reset_L=0, async): state=UNSYNC and en_q=0. prev_gray, bin_out,
//     bin_valid, locked, error, error_count, wrap and good_cnt are all 0.
//     Assertion mid-run clears these immediately, independent of clk.
//   - Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Registered, 1-cycle latency.
//   - en_q captures enable every cycle. The counter steps on the edge where enable
//     is 1, so the sample on the next edge is checked against en_q.
//   - Good check:
//       en_q=0: gray_in == prev_gray.
//       en_q=1: bin(gray_in) == (bin(prev_gray)+1) mod 2^WIDTH.
//     Any other value fails, including a multi-bit jump, a backward step, or a
//     change while en_q=0.
//   - Every edge outside reset: prev_gray<=gray_in and bin_out<=bin(gray_in).
//   - FSM:
//       UNSYNC: first edge after reset release captures the sample, sets
//         bin_valid=1, good_cnt=0, and moves to SYNC. No check is made.
//       SYNC: good check -> good_cnt++. When good_cnt reaches LOCK_COUNT, move to
//         LOCKED and set locked=1. Failed check -> good_cnt=0, stay in SYNC,
//         no error pulse.
//       LOCKED: good check -> stay. Failed check -> error=1 for one cycle,
//         error_count+1 (saturating), locked=0, good_cnt=0, move to SYNC.
//         prev_gray is reloaded with the offending sample.
//   - wrap pulses for one cycle on any good en_q=1 step from all-ones to zero,
//     in SYNC or LOCKED.
//   - error and wrap are mutually exclusive. error_count holds at its maximum;
//     it does not roll over.
//   - bin_valid stays 1 until the next reset.
// TESTING
//   1. Reset asserted mid-run while locked and error_count=3 -> every output is 0
//      immediately, before the next clk edge. After release, bin_valid=1 after
//      1 edge.
//   2. Counter model from 0 with enable=1 continuously -> locked=1 on the 3rd edge
//      after release. bin_out follows 0,1,2,..., wrap pulses once per 32 steps at
//      31->0, error_count stays 0.
//   3. Locked, enable=0, gray_in held at 5'b01101 for 10 cycles -> no error,
//      locked stays 1, bin_out=5'd9.
//   4. Locked, en_q=1, gray_in forced 5'b00011 -> 5'b00000 -> error pulses 1 cycle,
//      error_count=1, locked=0. After 2 good steps locked=1 again.
//   5. Locked, en_q=0, gray_in changes 5'b00001 -> 5'b00011 -> error pulse and
//      error_count increments.
//   6. ERR_CNT_W=2, five error injections each separated by a relock ->
//      error_count=3 after the 3rd, 4th and 5th errors, and no rollover.

Source files
------------

// File: rtl/gray_checker.sv
// gray_checker: monitors a WIDTH-bit Gray counter output and checks that each
// sample either holds (enable low) or advances by exactly one (enable high).
// Ports:
//   clk, reset_L      - rising-edge clock, asynchronous active-low reset
//   enable            - same enable net that drives the Gray counter
//   gray_in           - Gray-coded counter output being monitored
//   bin_out           - registered binary equivalent of gray_in
//   bin_valid         - bin_out holds a converted sample
//   locked            - enough consecutive good checks have been seen
//   error             - one-cycle pulse on a failed check while locked
//   error_count       - saturating count of error pulses
//   wrap              - one-cycle pulse on a good all-ones -> zero step
module gray_checker #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 locked,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic                 wrap
);

  localparam int unsigned GOOD_W = 4;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Binary bit i is the XOR of all Gray bits at and above position i.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  state_e               state_q, state_d;
  logic                 en_q, en_d;
  logic [WIDTH-1:0]     prev_gray_q, prev_gray_d;
  logic [WIDTH-1:0]     bin_out_q, bin_out_d;
  logic                 bin_valid_q, bin_valid_d;
  logic                 locked_q, locked_d;
  logic                 error_q, error_d;
  logic [ERR_CNT_W-1:0] error_count_q, error_count_d;
  logic                 wrap_q, wrap_d;
  logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;

  logic [WIDTH-1:0]     bin_in_c;
  logic                 check_ok_c;
  logic                 wrap_step_c;
  logic [GOOD_W-1:0]    good_inc_c;

  // Sample check. bin_out_q always equals bin(prev_gray_q), since both are
  // loaded from the same sample on the same edge and cleared together.
  always_comb begin
    bin_in_c    = gray2bin(gray_in);
    check_ok_c  = en_q ? (bin_in_c == bin_out_q + WIDTH'(1))
                       : (gray_in == prev_gray_q);
    wrap_step_c = en_q & (&bin_out_q);
    good_inc_c  = good_cnt_q + GOOD_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    en_d          = enable;
    prev_gray_d   = gray_in;
    bin_out_d     = bin_in_c;
    bin_valid_d   = bin_valid_q;
    locked_d      = locked_q;
    error_d       = 1'b0;
    error_count_d = error_count_q;
    wrap_d        = 1'b0;
    good_cnt_d    = good_cnt_q;

    case (state_q)
      ST_UNSYNC: begin
        bin_valid_d = 1'b1;
        good_cnt_d  = '0;
        state_d     = ST_SYNC;
      end
      ST_SYNC: begin
        if (check_ok_c) begin
          wrap_d     = wrap_step_c;
          good_cnt_d = good_inc_c;
          if (good_inc_c == GOOD_W'(LOCK_COUNT)) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end
        end else begin
          good_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (check_ok_c) begin
          wrap_d = wrap_step_c;
        end else begin
          error_d    = 1'b1;
          locked_d   = 1'b0;
          good_cnt_d = '0;
          state_d    = ST_SYNC;
          if (error_count_q != {ERR_CNT_W{1'b1}}) begin
            error_count_d = error_count_q + ERR_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_UNSYNC;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= ST_UNSYNC;
      en_q          <= 1'b0;
      prev_gray_q   <= '0;
      bin_out_q     <= '0;
      bin_valid_q   <= 1'b0;
      locked_q      <= 1'b0;
      error_q       <= 1'b0;
      error_count_q <= '0;
      wrap_q        <= 1'b0;
      good_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      prev_gray_q   <= prev_gray_d;
      bin_out_q     <= bin_out_d;
      bin_valid_q   <= bin_valid_d;
      locked_q      <= locked_d;
      error_q       <= error_d;
      error_count_q <= error_count_d;
      wrap_q        <= wrap_d;
      good_cnt_q    <= good_cnt_d;
    end
  end

  assign bin_out     = bin_out_q;
  assign bin_valid   = bin_valid_q;
  assign locked      = locked_q;
  assign error       = error_q;
  assign error_count = error_count_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_gray_checker.sv
// Testbench for gray_checker: an 8-bit-count instance and a 2-bit-count
// instance share all inputs; expected outputs are queued as each cycle is
// driven and compared one time unit after the clock edge.
module tb_gray_checker;

  logic       clk;
  logic       reset_L;
  logic       enable;
  logic [4:0] gray_in;

  logic [4:0] bin_out, bin_out2;
  logic       bin_valid, bin_valid2;
  logic       locked, locked2;
  logic       error, error2;
  logic [7:0] error_count;
  logic [1:0] error_count2;
  logic       wrap, wrap2;

  gray_checker #(.WIDTH(5), .ERR_CNT_W(8), .LOCK_COUNT(2)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .gray_in(gray_in),
    .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked), .error(error),
    .error_count(error_count), .wrap(wrap)
  );

  gray_checker #(.WIDTH(5), .ERR_CNT_W(2), .LOCK_COUNT(2)) dut2 (
    .clk(clk), .reset_L(reset_L), .enable(enable), .gray_in(gray_in),
    .bin_out(bin_out2), .bin_valid(bin_valid2), .locked(locked2), .error(error2),
    .error_count(error_count2), .wrap(wrap2)
  );

  typedef struct packed {
    logic [4:0] bin;
    logic       valid;
    logic       locked;
    logic       error;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       wrap;
  } out_t;

  typedef struct {
    logic       en;
    logic [4:0] g;
    int         b;
    bit         lk;
    bit         er;
    int         c;
  } vec_t;

  out_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = 5'(v);
    return b ^ (b >> 1);
  endfunction

  // Expected outputs once a sample has been captured (bin_valid = 1).
  function automatic out_t mk(input int b, input bit lk, input bit er,
                              input int c, input bit wr);
    out_t o;
    o.bin    = 5'(b);
    o.valid  = 1'b1;
    o.locked = lk;
    o.error  = er;
    o.cnt    = 8'(c);
    o.cnt2   = (c > 3) ? 2'd3 : 2'(c);
    o.wrap   = wr;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    bit   ok;
    act = '{bin: bin_out, valid: bin_valid, locked: locked, error: error,
            cnt: error_count, cnt2: error_count2, wrap: wrap};
    ok = (act == exp) &&
         ({bin_out2, bin_valid2, locked2, error2, wrap2} ==
          {exp.bin, exp.valid, exp.locked, exp.error, exp.wrap});
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got bin=%0d valid=%0b locked=%0b error=%0b cnt=%0d cnt2=%0d wrap=%0b (w2 bin=%0d v=%0b l=%0b e=%0b w=%0b); want bin=%0d valid=%0b locked=%0b error=%0b cnt=%0d cnt2=%0d wrap=%0b",
               name, act.bin, act.valid, act.locked, act.error, act.cnt, act.cnt2, act.wrap,
               bin_out2, bin_valid2, locked2, error2, wrap2,
               exp.bin, exp.valid, exp.locked, exp.error, exp.cnt, exp.cnt2, exp.wrap);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input logic en, input logic [4:0] g, input out_t exp,
                      input string name);
    out_t e;
    @(negedge clk);
    reset_L = 1'b1;
    enable  = en;
    gray_in = g;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, e);
  endtask

  // Assert reset mid-cycle and check that outputs clear without a clock edge.
  task automatic do_reset(input string name);
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    check(name, '0);
  endtask

  vec_t tbl[12];

  initial begin
    reset_L = 1'b1;
    enable  = 1'b0;
    gray_in = '0;

    // Hold then step, error while locked with enable low, relocks, backward jumps.
    tbl[0]  = '{1'b1, 5'b00000, 0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 5'b00001, 1, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 5'b00001, 1, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 5'b00011, 2, 1'b0, 1'b1, 1};
    tbl[4]  = '{1'b1, 5'b00010, 3, 1'b0, 1'b0, 1};
    tbl[5]  = '{1'b1, 5'b00110, 4, 1'b1, 1'b0, 1};
    tbl[6]  = '{1'b1, 5'b00000, 0, 1'b0, 1'b1, 2};
    tbl[7]  = '{1'b1, 5'b00001, 1, 1'b0, 1'b0, 2};
    tbl[8]  = '{1'b1, 5'b00011, 2, 1'b1, 1'b0, 2};
    tbl[9]  = '{1'b1, 5'b00000, 0, 1'b0, 1'b1, 3};
    tbl[10] = '{1'b1, 5'b00001, 1, 1'b0, 1'b0, 3};
    tbl[11] = '{1'b1, 5'b00011, 2, 1'b1, 1'b0, 3};

    // Free-running count from zero: lock on third edge, wrap at 31 -> 0.
    do_reset("reset_init");
    for (int i = 0; i < 40; i++) begin
      step(1'b1, gray(i % 32),
           mk(i % 32, i >= 2, 1'b0, 0, (i > 0) && (i % 32 == 0)),
           $sformatf("count_%0d", i));
    end

    // Advance to 9 then hold with enable low for ten cycles.
    step(1'b1, gray(8), mk(8, 1'b1, 1'b0, 0, 1'b0), "count_8");
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 5'b01101, mk(9, 1'b1, 1'b0, 0, 1'b0), $sformatf("hold_%0d", i));
    end

    // Table-driven error and relock sequence.
    do_reset("reset_locked");
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].g, mk(tbl[i].b, tbl[i].lk, tbl[i].er, tbl[i].c, 1'b0),
           $sformatf("tbl_%0d", i));
    end

    // Reset while locked with three errors logged.
    do_reset("reset_cnt3");
    step(1'b1, 5'b00000, mk(0, 1'b0, 1'b0, 0, 1'b0), "valid_after_release");
    step(1'b1, 5'b00001, mk(1, 1'b0, 1'b0, 0, 1'b0), "relock_1");
    step(1'b1, 5'b00011, mk(2, 1'b1, 1'b0, 0, 1'b0), "relock_2");

    // Five injected errors; the 2-bit counter saturates at 3.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 5'b00000, mk(0, 1'b0, 1'b1, k, 1'b0), $sformatf("inject_%0d", k));
      if (k < 5) begin
        step(1'b1, 5'b00001, mk(1, 1'b0, 1'b0, k, 1'b0), $sformatf("inject_%0d_good1", k));
        step(1'b1, 5'b00011, mk(2, 1'b1, 1'b0, k, 1'b0), $sformatf("inject_%0d_good2", k));
      end else begin
        // A failed check in SYNC restarts the lock count without an error pulse.
        step(1'b1, 5'b00110, mk(4, 1'b0, 1'b0, k, 1'b0), "sync_fail");
        step(1'b1, gray(5),  mk(5, 1'b0, 1'b0, k, 1'b0), "sync_good1");
        step(1'b1, gray(6),  mk(6, 1'b1, 1'b0, k, 1'b0), "sync_good2");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
